// File: rtl/pulse_safety_monitor_mc.sv
// ---------------------------------------------------------------------------
// pulse_safety_monitor_mc
//
// Purpose:
//   Multi-channel laser pulse limit checker. Each channel synchronises its
//   raw pulse input and checks three limits independently:
//     - minimum pulse width (evaluated on the falling edge)
//     - maximum pulse width (evaluated while the pulse is high)
//     - minimum rising-edge-to-rising-edge period
//   Faults latch until clear_fail. The first faulting channel since reset or
//   clear is captured; the lowest index wins a tie.
//
// Ports:
//   clk                 system clock
//   rstn                asynchronous active-low reset
//   laser_pulse         raw asynchronous pulse inputs, bit i = channel i
//   ch_enable           per-channel check enable
//   clear_fail          single-cycle pulse, clears all latched faults
//   pw_lower_limit      per-channel min pulse width (0 = check off)
//   pw_upper_limit      per-channel max pulse width (0 = check off)
//   period_lower_limit  per-channel min period (0 = check off)
//   pw_lower_fail       latched short-pulse faults
//   pw_upper_fail       latched long-pulse faults
//   rate_fail           latched period-too-short faults
//   fault_any           registered OR of all fault bits
//   first_fault_ch      index of first channel to fault
//   first_fault_valid   first_fault_ch is meaningful
//
// Limit fields: channel i occupies bits [i*CNT_W +: CNT_W].
// There is no valid/ready handshake; clear_fail is a plain one-cycle strobe.
// ---------------------------------------------------------------------------
module pulse_safety_monitor_mc #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_CH-1:0]       laser_pulse,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic                    clear_fail,
    input  logic [NUM_CH*CNT_W-1:0] pw_lower_limit,
    input  logic [NUM_CH*CNT_W-1:0] pw_upper_limit,
    input  logic [NUM_CH*CNT_W-1:0] period_lower_limit,
    output logic [NUM_CH-1:0]       pw_lower_fail,
    output logic [NUM_CH-1:0]       pw_upper_fail,
    output logic [NUM_CH-1:0]       rate_fail,
    output logic                    fault_any,
    output logic [2:0]              first_fault_ch,
    output logic                    first_fault_valid
);

    logic [SYNC_STAGES-1:0] r_sync [NUM_CH];
    logic [NUM_CH-1:0]      r_prev;
    logic [NUM_CH-1:0]      r_in_pulse;   // a rise was seen while enabled
    logic [NUM_CH-1:0]      r_armed;      // a previous rise exists for period check
    logic [CNT_W-1:0]       r_width_cnt  [NUM_CH];
    logic [CNT_W-1:0]       r_period_cnt [NUM_CH];
    logic [NUM_CH-1:0]      r_pw_lower_fail;
    logic [NUM_CH-1:0]      r_pw_upper_fail;
    logic [NUM_CH-1:0]      r_rate_fail;
    logic                   r_fault_any;
    logic [2:0]             r_first_ch;
    logic                   r_first_valid;

    logic [NUM_CH-1:0]      w_s;
    logic [NUM_CH-1:0]      w_rise;
    logic [NUM_CH-1:0]      w_fall;
    logic [NUM_CH-1:0]      w_set_lower;
    logic [NUM_CH-1:0]      w_set_upper;
    logic [NUM_CH-1:0]      w_set_rate;
    logic [NUM_CH-1:0]      w_new_fault;
    logic [CNT_W-1:0]       w_lo         [NUM_CH];
    logic [CNT_W-1:0]       w_up         [NUM_CH];
    logic [CNT_W-1:0]       w_per        [NUM_CH];
    logic [CNT_W-1:0]       w_width_inc  [NUM_CH];
    logic [CNT_W-1:0]       w_width_now  [NUM_CH];
    logic [CNT_W-1:0]       w_period_inc [NUM_CH];
    logic [2:0]             w_first_idx;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_lo[i]  = pw_lower_limit[i*CNT_W +: CNT_W];
            w_up[i]  = pw_upper_limit[i*CNT_W +: CNT_W];
            w_per[i] = period_lower_limit[i*CNT_W +: CNT_W];

            w_s[i]    = r_sync[i][SYNC_STAGES-1];
            w_rise[i] = w_s[i] & ~r_prev[i];
            w_fall[i] = ~w_s[i] & r_prev[i];

            w_width_inc[i]  = (&r_width_cnt[i])  ? r_width_cnt[i]  : r_width_cnt[i]  + CNT_W'(1);
            w_period_inc[i] = (&r_period_cnt[i]) ? r_period_cnt[i] : r_period_cnt[i] + CNT_W'(1);

            // Width including the current high cycle, so a pulse of upper+1
            // cycles is flagged at the edge closing its last high cycle.
            w_width_now[i] = w_rise[i] ? CNT_W'(1) : w_width_inc[i];

            w_set_upper[i] = ch_enable[i] & w_s[i] & (w_rise[i] | r_in_pulse[i]) &
                             (w_up[i] != '0) & (w_width_now[i] > w_up[i]);
            w_set_lower[i] = ch_enable[i] & w_fall[i] & r_in_pulse[i] &
                             (w_lo[i] != '0) & (r_width_cnt[i] < w_lo[i]);
            w_set_rate[i]  = ch_enable[i] & w_rise[i] & r_armed[i] &
                             (w_per[i] != '0) & (r_period_cnt[i] < w_per[i]);
        end
        w_new_fault = w_set_lower | w_set_upper | w_set_rate;

        // Scan downward so the lowest faulting index is the one that sticks.
        w_first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_new_fault[i]) w_first_idx = 3'(i);
        end
    end

    // Per-channel synchroniser, edge history and counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sync[i]       <= '0;
                r_width_cnt[i]  <= '0;
                r_period_cnt[i] <= '0;
            end
            r_prev     <= '0;
            r_in_pulse <= '0;
            r_armed    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], laser_pulse[i]};
                // prev tracks even when disabled, so enabling mid-pulse does
                // not fabricate a rise.
                r_prev[i] <= w_s[i];
                if (!ch_enable[i]) begin
                    r_width_cnt[i]  <= '0;
                    r_period_cnt[i] <= '0;
                    r_in_pulse[i]   <= 1'b0;
                    r_armed[i]      <= 1'b0;
                end else begin
                    if (w_rise[i]) begin
                        r_width_cnt[i] <= CNT_W'(1);
                        r_in_pulse[i]  <= 1'b1;
                    end else begin
                        if (w_s[i] && r_in_pulse[i]) r_width_cnt[i] <= w_width_inc[i];
                        if (w_fall[i])               r_in_pulse[i]  <= 1'b0;
                    end
                    if (w_rise[i]) begin
                        r_period_cnt[i] <= CNT_W'(1);
                        r_armed[i]      <= 1'b1;
                    end else begin
                        r_period_cnt[i] <= w_period_inc[i];
                    end
                end
            end
        end
    end

    // Fault latches; a set in the same cycle as clear_fail survives the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pw_lower_fail <= '0;
            r_pw_upper_fail <= '0;
            r_rate_fail     <= '0;
            r_fault_any     <= 1'b0;
            r_first_ch      <= '0;
            r_first_valid   <= 1'b0;
        end else begin
            r_pw_lower_fail <= (clear_fail ? '0 : r_pw_lower_fail) | w_set_lower;
            r_pw_upper_fail <= (clear_fail ? '0 : r_pw_upper_fail) | w_set_upper;
            r_rate_fail     <= (clear_fail ? '0 : r_rate_fail)     | w_set_rate;
            r_fault_any     <= |{r_pw_lower_fail, r_pw_upper_fail, r_rate_fail};
            if (clear_fail) begin
                r_first_valid <= |w_new_fault;
                r_first_ch    <= (|w_new_fault) ? w_first_idx : 3'd0;
            end else if (!r_first_valid && (|w_new_fault)) begin
                r_first_valid <= 1'b1;
                r_first_ch    <= w_first_idx;
            end
        end
    end

    assign pw_lower_fail     = r_pw_lower_fail;
    assign pw_upper_fail     = r_pw_upper_fail;
    assign rate_fail         = r_rate_fail;
    assign fault_any         = r_fault_any;
    assign first_fault_ch    = r_first_ch;
    assign first_fault_valid = r_first_valid;

endmodule

// File: tb/tb_pulse_safety_monitor_mc.sv
// ---------------------------------------------------------------------------
// tb_pulse_safety_monitor_mc
//
// Directed bench for pulse_safety_monitor_mc with NUM_CH=4, CNT_W=16.
// Inputs change 1 time unit after a rising clock edge; outputs are sampled
// at the same point, so every observation is well away from the edge.
// ---------------------------------------------------------------------------
module tb_pulse_safety_monitor_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    // Clock/reset
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [NUM_CH-1:0]       laser_pulse;
    logic [NUM_CH-1:0]       ch_enable;
    logic                    clear_fail;
    logic [NUM_CH*CNT_W-1:0] pw_lower_limit;
    logic [NUM_CH*CNT_W-1:0] pw_upper_limit;
    logic [NUM_CH*CNT_W-1:0] period_lower_limit;
    logic [NUM_CH-1:0]       pw_lower_fail;
    logic [NUM_CH-1:0]       pw_upper_fail;
    logic [NUM_CH-1:0]       rate_fail;
    logic                    fault_any;
    logic [2:0]              first_fault_ch;
    logic                    first_fault_valid;

    int checks   = 0;
    int failures = 0;

    pulse_safety_monitor_mc #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .laser_pulse        (laser_pulse),
        .ch_enable          (ch_enable),
        .clear_fail         (clear_fail),
        .pw_lower_limit     (pw_lower_limit),
        .pw_upper_limit     (pw_upper_limit),
        .period_lower_limit (period_lower_limit),
        .pw_lower_fail      (pw_lower_fail),
        .pw_upper_fail      (pw_upper_fail),
        .rate_fail          (rate_fail),
        .fault_any          (fault_any),
        .first_fault_ch     (first_fault_ch),
        .first_fault_valid  (first_fault_valid)
    );

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_limits(input int ch, input int lo, input int up, input int per);
        logic [31:0] v_lo, v_up, v_per;
        v_lo  = lo;
        v_up  = up;
        v_per = per;
        pw_lower_limit[ch*CNT_W +: CNT_W]     = v_lo[CNT_W-1:0];
        pw_upper_limit[ch*CNT_W +: CNT_W]     = v_up[CNT_W-1:0];
        period_lower_limit[ch*CNT_W +: CNT_W] = v_per[CNT_W-1:0];
    endtask

    // One pulse of w cycles on a channel, then idle so the next rise lands
    // exactly per cycles after this one.
    task automatic run_pulse(input int ch, input int w, input int per);
        laser_pulse[ch] = 1'b1;
        ticks(w);
        laser_pulse[ch] = 1'b0;
        ticks(per - w);
    endtask

    task automatic do_clear();
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
    endtask

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_lower"}, 32'(pw_lower_fail), 32'h0);
        check({tag, "_upper"}, 32'(pw_upper_fail), 32'h0);
        check({tag, "_rate"},  32'(rate_fail),     32'h0);
        check({tag, "_any"},   32'(fault_any),     32'h0);
        check({tag, "_ffch"},  32'(first_fault_ch), 32'h0);
        check({tag, "_ffv"},   32'(first_fault_valid), 32'h0);
    endtask

    initial begin
        rstn               = 1'b0;
        laser_pulse        = '0;
        ch_enable          = '0;
        clear_fail         = 1'b0;
        pw_lower_limit     = '0;
        pw_upper_limit     = '0;
        period_lower_limit = '0;
        set_limits(0, 10, 20, 100);
        set_limits(1, 10, 0, 0);
        set_limits(2, 0, 0, 100);
        set_limits(3, 0, 30, 0);
        ticks(3);
        check_all_zero("reset");
        rstn      = 1'b1;
        ch_enable = 4'hF;
        ticks(5);

        // ch0: in-limit pulses at period 100
        run_pulse(0, 10, 100);
        run_pulse(0, 20, 100);
        check("ch0_inlimit_lower", 32'(pw_lower_fail), 32'h0);
        check("ch0_inlimit_upper", 32'(pw_upper_fail), 32'h0);
        check("ch0_inlimit_rate",  32'(rate_fail),     32'h0);

        // ch0: W=21 -> upper fault right after the 21st synchronised high cycle
        laser_pulse[0] = 1'b1;
        ticks(21);
        laser_pulse[0] = 1'b0;
        tick();
        check("ch0_w21_before", 32'(pw_upper_fail), 32'h0);
        tick();
        check("ch0_w21_upper", 32'(pw_upper_fail), 32'h1);
        check("ch0_w21_any_lag", 32'(fault_any), 32'h0);
        tick();
        check("ch0_w21_any", 32'(fault_any), 32'h1);
        check("ch0_w21_ffch", 32'(first_fault_ch), 32'h0);
        check("ch0_w21_ffv", 32'(first_fault_valid), 32'h1);
        check("ch0_w21_rate", 32'(rate_fail), 32'h0);
        ticks(80);

        do_clear();
        check("clr1_upper", 32'(pw_upper_fail), 32'h0);
        check("clr1_ffv", 32'(first_fault_valid), 32'h0);
        tick();
        check("clr1_any", 32'(fault_any), 32'h0);

        // ch1: W=9 with lower=10 -> lower fault one cycle after the fall
        laser_pulse[1] = 1'b1;
        ticks(9);
        laser_pulse[1] = 1'b0;
        ticks(2);
        check("ch1_w9_fallcyc", 32'(pw_lower_fail), 32'h0);
        tick();
        check("ch1_w9_lower", 32'(pw_lower_fail), 32'h2);
        check("ch1_w9_ffch", 32'(first_fault_ch), 32'h1);
        ticks(20);
        do_clear();
        set_limits(1, 0, 0, 0);
        run_pulse(1, 9, 40);
        check("ch1_lo0_lower", 32'(pw_lower_fail), 32'h0);
        check("ch1_lo0_any", 32'(fault_any), 32'h0);

        // ch2: period checks
        run_pulse(2, 5, 100);
        run_pulse(2, 5, 99);
        check("ch2_p100_rate", 32'(rate_fail), 32'h0);
        run_pulse(2, 5, 50);
        check("ch2_p99_rate", 32'(rate_fail), 32'h4);
        check("ch2_p99_ffch", 32'(first_fault_ch), 32'h2);
        do_clear();

        // ch3 upper and ch1 lower faults set on the same edge
        set_limits(1, 10, 0, 0);
        for (int t = 0; t < 60; t++) begin
            laser_pulse[3] = (t < 35);
            laser_pulse[1] = (t >= 25 && t < 30);
            if (t == 33) begin
                check("simul_upper", 32'(pw_upper_fail), 32'h8);
                check("simul_lower", 32'(pw_lower_fail), 32'h2);
                check("simul_ffch", 32'(first_fault_ch), 32'h1);
                check("simul_ffv", 32'(first_fault_valid), 32'h1);
            end
            tick();
        end

        // clear_fail on the same edge as a new ch3 upper fault
        for (int t = 0; t < 60; t++) begin
            laser_pulse[3] = (t < 35);
            clear_fail     = (t == 32);
            if (t == 33) begin
                check("clrset_upper", 32'(pw_upper_fail), 32'h8);
                check("clrset_lower", 32'(pw_lower_fail), 32'h0);
                check("clrset_ffch", 32'(first_fault_ch), 32'h3);
                check("clrset_ffv", 32'(first_fault_valid), 32'h1);
            end
            tick();
        end
        clear_fail = 1'b0;
        do_clear();
        tick();

        // ch0 disabled: long pulses raise nothing
        ch_enable = 4'b1110;
        run_pulse(0, 50, 80);
        run_pulse(0, 50, 80);
        check("dis_upper", 32'(pw_upper_fail), 32'h0);
        check("dis_lower", 32'(pw_lower_fail), 32'h0);
        check("dis_rate", 32'(rate_fail), 32'h0);

        // re-enable: first rise unchecked, second rise 15 cycles later faults
        ch_enable = 4'hF;
        run_pulse(0, 12, 15);
        check("reen_first_rate", 32'(rate_fail), 32'h0);
        run_pulse(0, 12, 15);
        check("reen_second_rate", 32'(rate_fail), 32'h1);
        check("reen_upper", 32'(pw_upper_fail), 32'h0);
        check("reen_lower", 32'(pw_lower_fail), 32'h0);

        // reset mid-pulse clears everything without a clock edge
        laser_pulse[3] = 1'b1;
        ticks(10);
        rstn = 1'b0;
        #1;
        check_all_zero("midrst");
        laser_pulse[3] = 1'b0;
        ticks(3);
        rstn = 1'b1;
        ticks(3);

        // first pulse after reset is never rate-checked
        run_pulse(2, 5, 10);
        check("postrst_first_rate", 32'(rate_fail), 32'h0);
        run_pulse(2, 5, 10);
        check("postrst_second_rate", 32'(rate_fail), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
